count_wrap_tracker: RTL and testbench

//  Downstream consumer of the 4-bit up/down counter outputs. Samples the counter value every

---
 rtl/ctr_pkg.sv | 18 +
 rtl/ctr_evt_slot.sv | 54 +++++
 rtl/count_wrap_tracker.sv | 140 ++++++++++++++
 tb/tb_count_wrap_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// Shared types for the counter tracking blocks:
// tracker state encoding and event codes.
package ctr_pkg;

  typedef enum logic [2:0] {
    ACQUIRE,
    PROBE,
    LOCK_UP,
    LOCK_DOWN,
    FAULT
  } trk_state_e;

  localparam logic [1:0] EVT_WRAP_UP = 2'b00;
  localparam logic [1:0] EVT_WRAP_DN = 2'b01;
  localparam logic [1:0] EVT_GLITCH  = 2'b10;
  localparam logic [1:0] EVT_DIR     = 2'b11;

endpackage

// File: rtl/ctr_evt_slot.sv
// One-entry valid/ready holding register.
// New events are lost (sticky drop) while a held one waits.
module ctr_evt_slot #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         drop
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         drop_q, drop_d;
  logic         take;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    // accept into a free slot or one being drained this cycle
    take    = push && (!valid_q || pop_ready);
    if (take) begin
      valid_d = 1'b1;
      data_d  = push_data;
    end else if (push) begin
      drop_d  = 1'b1;
    end else if (valid_q && pop_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign drop  = drop_q;

endmodule

// File: rtl/count_wrap_tracker.sv
// Tracks an up/down counter, extends it by counting wraps,
// and reports wrap/glitch/direction events.
module count_wrap_tracker #(
  parameter int CW    = 4,
  parameter int EXT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CW-1:0]       count_in,
  input  logic                count_en,
  input  logic                clear,
  output logic [EXT_W+CW-1:0] ext_count,
  output logic                dir_up,
  output logic                locked,
  output logic                wrap_pulse,
  output logic                err,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_code,
  output logic                evt_drop
);
  import ctr_pkg::*;

  trk_state_e       state_q, state_d;
  logic [CW-1:0]    prev_q, prev_d;
  logic [EXT_W-1:0] acc_q, acc_d;
  logic             dir_q, dir_d;
  logic             lock_q, lock_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [CW-1:0]    delta;
  logic             step_up, step_dn, hold, jump;
  logic             wrap_up, wrap_dn;
  logic             ev_push;
  logic [1:0]       ev_code;

  always_comb begin
    delta   = count_in - prev_q;
    step_up = (delta == CW'(1));
    step_dn = (delta == '1);
    hold    = (delta == '0);
    jump    = !(step_up || step_dn || hold);
    wrap_up = (prev_q == '1) && (count_in == '0);
    wrap_dn = (prev_q == '0) && (count_in == '1);

    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    dir_d   = dir_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    ev_push = 1'b0;
    ev_code = EVT_WRAP_UP;

    if (count_en) begin
      prev_d = count_in;
      unique case (state_q)
        ACQUIRE: state_d = PROBE;
        FAULT:   state_d = FAULT;
        default: begin
          if (jump) begin
            state_d = FAULT;
            err_d   = 1'b1;
            ev_push = 1'b1;
            ev_code = EVT_GLITCH;
          end else begin
            wrap_d = wrap_up || wrap_dn;
            if (wrap_up) acc_d = acc_q + EXT_W'(1);
            if (wrap_dn) acc_d = acc_q - EXT_W'(1);
            if (wrap_d) begin
              ev_push = 1'b1;
              ev_code = wrap_up ? EVT_WRAP_UP : EVT_WRAP_DN;
            end
            // direction change outranks the wrap code
            if (step_up) begin
              dir_d   = 1'b1;
              state_d = LOCK_UP;
              if (state_q == LOCK_DOWN) begin
                ev_push = 1'b1;
                ev_code = EVT_DIR;
              end
            end
            if (step_dn) begin
              dir_d   = 1'b0;
              state_d = LOCK_DOWN;
              if (state_q == LOCK_UP) begin
                ev_push = 1'b1;
                ev_code = EVT_DIR;
              end
            end
          end
        end
      endcase
    end

    lock_d = (state_d == LOCK_UP) || (state_d == LOCK_DOWN);
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q <= ACQUIRE;
      prev_q  <= '0;
      acc_q   <= '0;
      dir_q   <= 1'b0;
      lock_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      lock_q  <= lock_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  ctr_evt_slot #(
    .W(2)
  ) u_slot (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (clear),
    .push      (ev_push),
    .push_data (ev_code),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .data      (evt_code),
    .drop      (evt_drop)
  );

  assign ext_count  = {acc_q, prev_q};
  assign dir_up     = dir_q;
  assign locked     = lock_q;
  assign wrap_pulse = wrap_q;
  assign err        = err_q;

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Scoreboard bench for count_wrap_tracker: a behavioural
// model queues expected outputs, popped after each edge.
module tb_count_wrap_tracker;

  logic        clk = 1'b0;
  logic        reset, clear, count_en, evt_ready;
  logic [3:0]  count_in;
  logic [11:0] ext_count;
  logic        dir_up, locked, wrap_pulse, err;
  logic        evt_valid, evt_drop;
  logic [1:0]  evt_code;

  always #5 clk = ~clk;

  count_wrap_tracker #(.CW(4), .EXT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .count_en   (count_en),
    .clear      (clear),
    .ext_count  (ext_count),
    .dir_up     (dir_up),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err        (err),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_drop   (evt_drop)
  );

  typedef struct packed {
    logic [11:0] ext;
    logic        dir;
    logic        lck;
    logic        wrp;
    logic        er;
    logic        ev;
    logic [1:0]  code;
    logic        drp;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  localparam int S_ACQ = 0, S_PRB = 1, S_UP = 2, S_DN = 3, S_FLT = 4;

  int         m_st;
  logic [3:0] m_prev;
  logic [7:0] m_acc;
  logic       m_dir, m_wrap, m_err, m_ev, m_drop;
  logic [1:0] m_code;

  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic model(input logic rn, input logic cl, input logic en,
                       input logic [3:0] c, input logic rdy);
    logic [3:0] d;
    logic       ev, wu, wd;
    logic [1:0] code;
    if (!rn || cl) begin
      m_st = S_ACQ; m_prev = 0; m_acc = 0; m_dir = 0;
      m_wrap = 0; m_err = 0; m_ev = 0; m_code = 0; m_drop = 0;
      return;
    end
    ev = 0; code = 0; m_wrap = 0;
    if (en) begin
      d  = c - m_prev;
      wu = (m_prev == 4'hF && c == 4'h0);
      wd = (m_prev == 4'h0 && c == 4'hF);
      if (m_st == S_ACQ) m_st = S_PRB;
      else if (m_st != S_FLT) begin
        if (d != 4'h0 && d != 4'h1 && d != 4'hF) begin
          m_st = S_FLT; m_err = 1; ev = 1; code = 2'b10;
        end else begin
          if (wu) begin m_acc++; m_wrap = 1; ev = 1; code = 2'b00; end
          if (wd) begin m_acc--; m_wrap = 1; ev = 1; code = 2'b01; end
          if (d == 4'h1) begin
            if (m_st == S_DN) begin ev = 1; code = 2'b11; end
            m_st = S_UP; m_dir = 1;
          end
          if (d == 4'hF) begin
            if (m_st == S_UP) begin ev = 1; code = 2'b11; end
            m_st = S_DN; m_dir = 0;
          end
        end
      end
      m_prev = c;
    end
    if (ev) begin
      if (!m_ev || rdy) begin m_ev = 1; m_code = code; end
      else m_drop = 1;
    end else if (m_ev && rdy) m_ev = 0;
  endtask

  task automatic cyc(input logic rn, input logic cl, input logic en,
                     input logic [3:0] c, input logic rdy);
    exp_t e;
    reset = rn; clear = cl; count_en = en;
    count_in = c; evt_ready = rdy;
    model(rn, cl, en, c, rdy);
    e.ext = {m_acc, m_prev};
    e.dir = m_dir;
    e.lck = (m_st == S_UP || m_st == S_DN);
    e.wrp = m_wrap;
    e.er  = m_err;
    e.ev  = m_ev;
    e.code = m_code;
    e.drp = m_drop;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ext_count", ext_count, 12'(e.ext));
    check("dir_up", 12'(dir_up), 12'(e.dir));
    check("locked", 12'(locked), 12'(e.lck));
    check("wrap_pulse", 12'(wrap_pulse), 12'(e.wrp));
    check("err", 12'(err), 12'(e.er));
    check("evt_valid", 12'(evt_valid), 12'(e.ev));
    if (e.ev) check("evt_code", 12'(evt_code), 12'(e.code));
    check("evt_drop", 12'(evt_drop), 12'(e.drp));
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 4'h0, 1);
    cyc(0, 0, 0, 4'h0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // 1: up-count with a wrap
    do_reset();
    check("rst_ext", ext_count, 12'h000);
    check("rst_valid", 12'(evt_valid), 12'h0);
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, 1, 4'(i), 1);
      if (i == 1) check("t1_locked", 12'(locked), 12'h1);
      if (i == 16) begin
        check("t1_ext", ext_count, 12'h010);
        check("t1_wrap", 12'(wrap_pulse), 12'h1);
        check("t1_code", 12'(evt_code), 12'h0);
      end
    end

    // 2: down-count from reset
    do_reset();
    for (int i = 15; i >= 0; i--) cyc(1, 0, 1, 4'(i), 1);
    cyc(1, 0, 1, 4'hF, 1);
    check("t2_ext", ext_count, 12'hFFF);
    check("t2_code", 12'(evt_code), 12'h1);
    for (int i = 14; i >= 0; i--) cyc(1, 0, 1, 4'(i), 1);
    cyc(1, 0, 1, 4'hF, 1);
    check("t2_ext2", ext_count, 12'hFEF);

    // 3: direction change
    do_reset();
    for (int i = 0; i <= 5; i++) cyc(1, 0, 1, 4'(i), 1);
    cyc(1, 0, 1, 4'h4, 1);
    check("t3_ext", ext_count, 12'h004);
    check("t3_dir", 12'(dir_up), 12'h0);
    check("t3_code", 12'(evt_code), 12'h3);

    // 4: glitch into fault, then clear
    do_reset();
    for (int i = 0; i <= 3; i++) cyc(1, 0, 1, 4'(i), 1);
    cyc(1, 0, 1, 4'h9, 1);
    check("t4_err", 12'(err), 12'h1);
    check("t4_code", 12'(evt_code), 12'h2);
    check("t4_locked", 12'(locked), 12'h0);
    cyc(1, 0, 1, 4'hA, 1);
    cyc(1, 0, 1, 4'hB, 1);
    check("t4_quiet", 12'(evt_valid), 12'h0);
    check("t4_ext", ext_count, 12'h00B);
    cyc(1, 1, 1, 4'hC, 1);
    check("t4_clr_err", 12'(err), 12'h0);
    cyc(1, 0, 1, 4'h3, 1);
    cyc(1, 0, 1, 4'h4, 1);
    check("t4_relock", 12'(locked), 12'h1);

    // 5: held event, drop, back-to-back replacement
    do_reset();
    for (int i = 13; i <= 15; i++) cyc(1, 0, 1, 4'(i), 0);
    cyc(1, 0, 1, 4'h0, 0);
    for (int i = 1; i <= 15; i++) cyc(1, 0, 1, 4'(i), 0);
    cyc(1, 0, 1, 4'h0, 0);
    check("t5_drop", 12'(evt_drop), 12'h1);
    check("t5_hold", 12'(evt_code), 12'h0);
    check("t5_ext", ext_count, 12'h020);
    cyc(1, 0, 1, 4'hF, 1);
    check("t5_repl_v", 12'(evt_valid), 12'h1);
    check("t5_repl_c", 12'(evt_code), 12'h3);
    check("t5_ext2", ext_count, 12'h01F);

    // 6: gated holds, then reset over a pending event
    do_reset();
    for (int i = 0; i <= 2; i++) cyc(1, 0, 1, 4'(i), 1);
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) cyc(1, 0, 0, 4'($urandom_range(0, 15)), 1);
      else cyc(1, 0, 1, 4'h2, 1);
    check("t6_ext", ext_count, 12'h002);
    check("t6_locked", 12'(locked), 12'h1);
    cyc(1, 0, 1, 4'h1, 0);
    check("t6_pend", 12'(evt_valid), 12'h1);
    cyc(0, 0, 0, 4'h0, 0);
    check("t6_flush", 12'(evt_valid), 12'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
